// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, half-bit start qualification,
// LSB-first deserializer and a show-ahead receive FIFO with sticky error flags.
module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_en_i,
  input  logic                  rx_bit_i,
  input  logic                  rx_ren_i,
  input  logic                  err_clr_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CNT_W    = $clog2(BAUD_DIV);
  localparam int BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    sync_q, rx_s_q;
  logic                    push, stop_bad;

  logic [AW:0]             wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic                    frame_err_q, overrun_q;
  logic                    empty, full, pop, wr_en, overrun_set;

  // Synchronizer idles high so a reset never looks like a start edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      sync_q <= rx_bit_i;
      rx_s_q <= sync_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    push       = 1'b0;
    stop_bad   = 1'b0;
    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        if (rx_en_i && !rx_s_q) state_d = START;
      end
      START: begin
        if (baud_cnt_q == HALF_LAST) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d         = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == BIT_LAST) state_d = STOP;
          else                       bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          state_d    = IDLE;
          push       = rx_s_q;
          stop_bad   = !rx_s_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop         = rx_ren_i && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign wr_en       = push && (!full || pop);
  assign overrun_set = push && full && !pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (stop_bad)       frame_err_q <= 1'b1;
      else if (err_clr_i) frame_err_q <= 1'b0;
      if (overrun_set)    overrun_q   <= 1'b1;
      else if (err_clr_i) overrun_q   <= 1'b0;
    end
  end

  assign dout_o      = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o     = empty;
  assign full_o      = full;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a behavioural serial transmitter drives frames while a
// byte-queue model of the receive FIFO and flags is compared with the DUT every cycle.
module tb_uart_rx;

  localparam int BD    = 32;   // 3.2 MHz / 100 kbaud
  localparam int HD    = BD / 2;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst, rx_en, rx_bit, rx_ren, err_clr;
  logic [7:0] dout;
  logic       empty, full, ferr, ovr;

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQ  (3_200_000),
    .BAUD_RATE (100_000),
    .DATA_WIDTH(8),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_en_i    (rx_en),
    .rx_bit_i   (rx_bit),
    .rx_ren_i   (rx_ren),
    .err_clr_i  (err_clr),
    .dout_o     (dout),
    .empty_o    (empty),
    .full_o     (full),
    .frame_err_o(ferr),
    .overrun_o  (ovr)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] mq[$];
  bit         m_ferr = 0, m_ovr = 0, model_valid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model-vs-DUT comparison whenever no frame is in flight.
  always @(negedge clk) begin
    if (model_valid && !rst) begin
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == DEPTH);
      if (mq.size() > 0) chk("dout", dout, mq[0]);
      chk("frame_err", ferr, m_ferr);
      chk("overrun", ovr, m_ovr);
    end
  end

  // Behavioural transmitter plus model update once the frame is over.
  task automatic send_frame(input logic [7:0] d, input logic stop = 1'b1, input int drop_at = -1);
    bit accepted;
    @(negedge clk);
    model_valid = 0;
    accepted    = rx_en;
    rx_bit      = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i == drop_at) rx_en = 1'b0;
      rx_bit = d[i];
      repeat (BD) @(negedge clk);
    end
    rx_bit = stop;
    repeat (BD) @(negedge clk);
    rx_bit = 1'b1;
    if (accepted) begin
      if (!stop)                  m_ferr = 1;
      else if (mq.size() == DEPTH) m_ovr = 1;
      else                         mq.push_back(d);
    end
    repeat (BD) @(negedge clk);
    model_valid = 1;
    $display("frame %02h stop=%0d en=%0d fifo=%0d", d, stop, accepted, mq.size());
  endtask

  task automatic pop(input logic [7:0] exp, input bit use_exp);
    @(negedge clk);
    if (use_exp) chk("pop_data", dout, exp);
    $display("pop  %02h empty=%0d", dout, empty);
    rx_ren = 1'b1;
    @(posedge clk);
    #1;
    rx_ren = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic clr_err();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    m_ferr  = 0;
    m_ovr   = 0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_en = 1'b1; rx_bit = 1'b1; rx_ren = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_empty", empty, 1); chk("rst_full", full, 0);
    chk("rst_ferr", ferr, 0);   chk("rst_ovr", ovr, 0);
    chk("rst_dout", dout, 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    model_valid = 1;

    // Loopback sequence with first-frame latency measurement
    fork
      send_frame(8'h01);
      begin
        int cyc = 0;
        @(negedge clk);
        while (empty && cyc < 400) begin
          @(posedge clk);
          #1;
          cyc++;
        end
        chk("latency_in_window", (cyc >= 2 + HD + 9 * BD - 1) && (cyc <= 2 + HD + 9 * BD + 3), 1);
      end
    join
    send_frame(8'h09);
    send_frame(8'h00);
    send_frame(8'h07);
    chk("lb_not_empty", empty, 0);
    pop(8'h01, 1); pop(8'h09, 1); pop(8'h00, 1); pop(8'h07, 1);
    @(negedge clk);
    chk("lb_empty_after", empty, 1);
    chk("lb_ferr", ferr, 0);
    chk("lb_ovr", ovr, 0);

    // False start shorter than half a bit
    @(negedge clk);
    rx_bit = 1'b0;
    repeat (10) @(negedge clk);
    rx_bit = 1'b1;
    repeat (40) @(negedge clk);
    chk("fs_empty", empty, 1);
    chk("fs_ferr", ferr, 0);
    send_frame(8'hA5);
    pop(8'hA5, 1);

    // Framing error
    send_frame(8'h3C, 1'b0);
    chk("fe_flag", ferr, 1);
    chk("fe_empty", empty, 1);
    clr_err();
    @(negedge clk);
    chk("fe_cleared", ferr, 0);

    // Overrun and pointer wrap
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i));
      if (i == 15) chk("ov_full", full, 1);
    end
    chk("ov_flag", ovr, 1);
    for (int i = 0; i < 16; i++) pop(8'(i), 1);
    pop(8'h00, 0);
    @(negedge clk);
    chk("ov_empty_after_extra_pop", empty, 1);
    send_frame(8'h31); send_frame(8'h32); send_frame(8'h33);
    chk("wrap_head", dout, 8'h31);

    // Reset in the middle of a frame
    @(negedge clk);
    model_valid = 0;
    rx_bit = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_bit = i[0] ? 1'b0 : 1'b1;
      repeat (BD) @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_empty", empty, 1); chk("mid_rst_full", full, 0);
    chk("mid_rst_ferr", ferr, 0);   chk("mid_rst_ovr", ovr, 1'b0);
    chk("mid_rst_dout", dout, 8'h00);
    mq.delete(); m_ferr = 0; m_ovr = 0;
    rx_bit = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    model_valid = 1;
    send_frame(8'h81);
    chk("post_rst_head", dout, 8'h81);
    pop(8'h81, 1);
    @(negedge clk);
    chk("post_rst_single", empty, 1);

    // Enable gating
    rx_en = 1'b0;
    send_frame(8'h42);
    chk("en_off_empty", empty, 1);
    rx_en = 1'b1;
    send_frame(8'h24, 1'b1, 4);
    rx_en = 1'b1;
    chk("en_drop_received", empty, 0);
    chk("en_drop_data", dout, 8'h24);
    pop(8'h24, 1);
    @(negedge clk);
    chk("final_empty", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
